fp_round_seq: RTL and testbench
===============================

// Module: fp_round_seq
// PURPOSE
//  Multi-cycle IEEE-style rounder for the FPU datapath, sitting between the
//  normaliser (producer) and the result packer (consumer). Takes an unrounded
//  significand with guard/round/sticky bits and applies the rounding mode.
//  Detects all-ones carry-out and renormalises; saturates on overflow.
//  Valid/ready handshake on both sides; one transaction in flight.
// PARAMETERS
//  N  11  significand width incl. hidden bit
//  E  5   exponent width
// PORTS
//  clk            in   1    clock, rising edge
//  rst            in   1    asynchronous, active-high reset
//  in_valid       in   1    input transaction valid
//  in_ready       out  1    block can accept (high only in IDLE)
//  sign_in        in   1    sign
//  exp_in         in   E    biased exponent
//  sig_in         in   N    significand, MSB = hidden bit
//  grs_in         in   3    {guard, round, sticky}
//  rm_in          in   2    rounding mode: 0 RNE, 1 RTZ, 2 RUP (+inf), 3 RDN (-inf)
//  out_valid      out  1    result valid, held until out_ready
//  out_ready      in   1    consumer accepts result
//  sign_out       out  1    sign (equals sign_in)
//  exp_out        out  E    rounded exponent
//  sig_out        out  N    rounded significand
//  flag_inexact   out  1    [FP_ROUND_FLAGS_EN only] grs != 0
//  flag_overflow  out  1    [FP_ROUND_FLAGS_EN only] exponent saturated
// BEHAVIOUR
//  - Reset: state IDLE; in_ready=1; out_valid=0; sign/exp/sig_out=0; flags=0.
//  - FSM: IDLE -(in_valid)-> ROUND -> NORM -> DONE -(out_ready)-> IDLE.
//  - Accept on edge where in_valid&&in_ready; operands registered. out_valid
//    rises 3 edges later (ROUND, NORM, DONE). Max throughput 1 per 4 cycles.
//  - ROUND: inc = RNE: g&(r|s|sig[0]); RTZ: 0; RUP: ~sign&(g|r|s);
//    RDN: sign&(g|r|s). Register {carry,sum} = sig + inc in N+1 bits.
//  - NORM: carry=1 (sig all ones & inc) -> sig_out={1'b1,{N-1{0}}}, exp+1.
//    If resulting exp == {E{1}}: overflow. RNE, or RUP with sign=0, or RDN with
//    sign=1 -> inf (exp all ones, sig 0); otherwise max finite
//    (exp = {E{1}}-1, sig all ones).
//  - exp_in == {E{1}} (inf/NaN): pass through unchanged, inc forced 0, no flags.
//  - exp_in == 0 (subnormal): rounded normally; carry into hidden bit sets exp=1.
//  - DONE: outputs stable while out_valid && !out_ready; in_valid ignored.
//    Return to IDLE on out_ready; out_valid drops the following edge.
//  - Reset mid-operation: transaction dropped, all outputs to reset values.
//  - No combinational path from in_valid to out_valid or out_ready to in_ready.
// CONFIGURATION
//  FP_ROUND_FLAGS_EN defined: flag_inexact/flag_overflow ports present,
//    registered alongside the result, valid with out_valid.
//  Undefined: flag ports and their logic absent; datapath identical.
// STRUCTURE
//  Package fp_round_pkg: rm_e enum (RM_RNE, RM_RTZ, RM_RUP, RM_RDN),
//    state_e enum (S_IDLE, S_ROUND, S_NORM, S_DONE).
//  Sub-module round_incr: combinational inc decision + all-ones carry detect
//    (reduction over sig), instantiated once in ROUND stage.
// TESTING (N=11, E=5)
//  1 RNE carry: sig=7FF grs=100 exp=10 -> sig_out=400 exp_out=11, 3 edges.
//  2 RNE tie: sig=402 grs=100 -> 402; sig=403 grs=100 -> 404.
//  3 RTZ: sig=7FF grs=111 exp=10 -> 7FF exp 10; inexact=1 if flags enabled.
//  4 Overflow: exp=30 sig=7FF grs=100 RNE -> exp 31 sig 000 overflow=1;
//    same with RTZ -> exp 30 sig 7FF.
//  5 Backpressure: out_ready=0 for 5 cycles -> outputs held, in_ready=0;
//    out_ready=1 -> IDLE, next input accepted.
//  6 rst pulse during NORM -> out_valid=0, in_ready=1; no result emitted.

Source files
------------

// File: rtl/fp_round_pkg.sv
// Shared types for the sequential FP rounder: rounding modes and FSM states.
package fp_round_pkg;

    typedef enum logic [1:0] {
        RM_RNE = 2'd0,
        RM_RTZ = 2'd1,
        RM_RUP = 2'd2,
        RM_RDN = 2'd3
    } rm_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_NORM  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/round_incr.sv
// Combinational round-up decision plus all-ones carry-out detect.
module round_incr
    import fp_round_pkg::*;
#(
    parameter int N = 11
) (
    input  logic [N-1:0] sig_i,
    input  logic [2:0]   grs_i,
    input  rm_e          rm_i,
    input  logic         sign_i,
    input  logic         special_i,
    output logic         inc_o,
    output logic         carry_o
);

    logic any_rem;
    logic inc_raw;

    assign any_rem = |grs_i;

    always_comb begin
        inc_raw = 1'b0;
        case (rm_i)
            RM_RNE:  inc_raw = grs_i[2] & (grs_i[1] | grs_i[0] | sig_i[0]);
            RM_RTZ:  inc_raw = 1'b0;
            RM_RUP:  inc_raw = ~sign_i & any_rem;
            RM_RDN:  inc_raw = sign_i & any_rem;
            default: inc_raw = 1'b0;
        endcase
    end

    // Inf/NaN operands are never rounded.
    assign inc_o   = inc_raw & ~special_i;
    assign carry_o = (&sig_i) & inc_o;

endmodule

// File: rtl/fp_round_seq.sv
// Multi-cycle rounder: accept -> ROUND -> NORM -> DONE, one transaction in flight.
// Optional flag outputs enabled by defining FP_ROUND_FLAGS_EN.
module fp_round_seq
    import fp_round_pkg::*;
#(
    parameter int N = 11,
    parameter int E = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         sign_in,
    input  logic [E-1:0] exp_in,
    input  logic [N-1:0] sig_in,
    input  logic [2:0]   grs_in,
    input  logic [1:0]   rm_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         sign_out,
    output logic [E-1:0] exp_out,
    output logic [N-1:0] sig_out
`ifdef FP_ROUND_FLAGS_EN
    ,
    output logic         flag_inexact,
    output logic         flag_overflow
`endif
);

    state_e state_q, state_d;

    logic         sign_q;
    logic [E-1:0] exp_q;
    logic [N-1:0] sig_q;
    logic [2:0]   grs_q;
    rm_e          rm_q;
    logic [N:0]   sum_q;

    logic         special;
    logic         inc;
    logic         carry;
    logic         accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = S_ROUND;
            end
            S_ROUND: state_d = S_NORM;
            S_NORM:  state_d = S_DONE;
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign accept  = (state_q == S_IDLE) && in_valid;
    assign special = (exp_q == {E{1'b1}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_q <= 1'b0;
            exp_q  <= '0;
            sig_q  <= '0;
            grs_q  <= '0;
            rm_q   <= RM_RNE;
        end else if (accept) begin
            sign_q <= sign_in;
            exp_q  <= exp_in;
            sig_q  <= sig_in;
            grs_q  <= grs_in;
            rm_q   <= rm_e'(rm_in);
        end
    end

    round_incr #(.N(N)) u_round_incr (
        .sig_i     (sig_q),
        .grs_i     (grs_q),
        .rm_i      (rm_q),
        .sign_i    (sign_q),
        .special_i (special),
        .inc_o     (inc),
        .carry_o   (carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else if (state_q == S_ROUND) begin
            sum_q <= {carry, sig_q + {{(N-1){1'b0}}, inc}};
        end
    end

    // Exponent bumps on all-ones carry-out, or when a subnormal rounds into the hidden bit.
    logic         bump;
    logic [E-1:0] exp_r;
    logic [N-1:0] sig_r;
    logic         ovf;
    logic         to_inf;
    logic [E-1:0] exp_d;
    logic [N-1:0] sig_d;

    assign bump   = sum_q[N] | ((exp_q == '0) & ~sig_q[N-1] & sum_q[N-1]);
    assign exp_r  = exp_q + {{(E-1){1'b0}}, bump};
    assign sig_r  = sum_q[N] ? {1'b1, {(N-1){1'b0}}} : sum_q[N-1:0];
    assign ovf    = ~special & (exp_r == {E{1'b1}});
    assign to_inf = (rm_q == RM_RNE) | ((rm_q == RM_RUP) & ~sign_q) | ((rm_q == RM_RDN) & sign_q);

    always_comb begin
        exp_d = exp_r;
        sig_d = sig_r;
        if (special) begin
            exp_d = exp_q;
            sig_d = sig_q;
        end else if (ovf) begin
            if (to_inf) begin
                exp_d = {E{1'b1}};
                sig_d = '0;
            end else begin
                exp_d = {{(E-1){1'b1}}, 1'b0};
                sig_d = {N{1'b1}};
            end
        end
    end

    logic         sign_out_q;
    logic [E-1:0] exp_out_q;
    logic [N-1:0] sig_out_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_out_q <= 1'b0;
            exp_out_q  <= '0;
            sig_out_q  <= '0;
        end else if (state_q == S_NORM) begin
            sign_out_q <= sign_q;
            exp_out_q  <= exp_d;
            sig_out_q  <= sig_d;
        end
    end

    assign sign_out = sign_out_q;
    assign exp_out  = exp_out_q;
    assign sig_out  = sig_out_q;

`ifdef FP_ROUND_FLAGS_EN
    logic inexact_q;
    logic overflow_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inexact_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else if (state_q == S_NORM) begin
            inexact_q  <= ~special & (|grs_q);
            overflow_q <= ovf;
        end
    end

    assign flag_inexact  = inexact_q;
    assign flag_overflow = overflow_q;
`endif

endmodule

// File: tb/tb_fp_round_seq.sv
// Randomised bench for fp_round_seq with an arithmetic reference model and scoreboard queue.
module tb_fp_round_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        sign_in;
    logic [4:0]  exp_in;
    logic [10:0] sig_in;
    logic [2:0]  grs_in;
    logic [1:0]  rm_in;
    logic        out_valid;
    logic        out_ready;
    logic        sign_out;
    logic [4:0]  exp_out;
    logic [10:0] sig_out;
`ifdef FP_ROUND_FLAGS_EN
    logic        flag_inexact;
    logic        flag_overflow;
`endif

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic        sign;
        logic [4:0]  e;
        logic [10:0] s;
        logic        ix;
        logic        ov;
    } res_t;

    res_t expq[$];

    always #5 clk = ~clk;

    fp_round_seq #(.N(11), .E(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sign_in   (sign_in),
        .exp_in    (exp_in),
        .sig_in    (sig_in),
        .grs_in    (grs_in),
        .rm_in     (rm_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sign_out  (sign_out),
        .exp_out   (exp_out),
        .sig_out   (sig_out)
`ifdef FP_ROUND_FLAGS_EN
        ,
        .flag_inexact  (flag_inexact),
        .flag_overflow (flag_overflow)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: grs is the discarded fraction in eighths of an ulp.
    function automatic res_t model(input logic s, input logic [4:0] e, input logic [10:0] sg,
                                   input logic [2:0] g, input logic [1:0] rm);
        res_t r;
        int   v;
        int   ex;
        int   frac;
        int   up;
        r.sign = s;
        r.ix   = 1'b0;
        r.ov   = 1'b0;
        if (e == 5'd31) begin
            r.e = e;
            r.s = sg;
            return r;
        end
        frac = int'(g);
        r.ix = (frac != 0);
        case (rm)
            2'd0:    up = (frac > 4 || (frac == 4 && (int'(sg) % 2 == 1))) ? 1 : 0;
            2'd1:    up = 0;
            2'd2:    up = (!s && frac != 0) ? 1 : 0;
            default: up = (s && frac != 0) ? 1 : 0;
        endcase
        v  = int'(sg) + up;
        ex = int'(e);
        if (v == 2048) begin
            v  = 1024;
            ex = ex + 1;
        end else if (ex == 0 && int'(sg) < 1024 && v >= 1024) begin
            ex = 1;
        end
        if (ex == 31) begin
            r.ov = 1'b1;
            if (rm == 2'd0 || (rm == 2'd2 && !s) || (rm == 2'd3 && s)) begin
                r.e = 5'd31;
                r.s = 11'h000;
            end else begin
                r.e = 5'd30;
                r.s = 11'h7FF;
            end
        end else begin
            r.e = ex[4:0];
            r.s = v[10:0];
        end
        return r;
    endfunction

    // Every cycle a result is presented, it must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (expq.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_result: out_valid=1 with nothing outstanding at %0t", $time);
            end else begin
                chk("sign_out", sign_out, expq[0].sign);
                chk("exp_out", exp_out, expq[0].e);
                chk("sig_out", sig_out, expq[0].s);
`ifdef FP_ROUND_FLAGS_EN
                chk("flag_inexact", flag_inexact, expq[0].ix);
                chk("flag_overflow", flag_overflow, expq[0].ov);
`endif
            end
        end
    end

    always @(posedge clk) begin
        if (out_valid && out_ready && expq.size() > 0) void'(expq.pop_front());
    end

    task automatic run_txn(input logic s, input logic [4:0] e, input logic [10:0] sg,
                           input logic [2:0] g, input logic [1:0] rm, input int hold,
                           output res_t got);
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        chk("out_valid_idle", out_valid, 0);
        sign_in  = s;
        exp_in   = e;
        sig_in   = sg;
        grs_in   = g;
        rm_in    = rm;
        in_valid = 1'b1;
        @(posedge clk);
        expq.push_back(model(s, e, sg, g, rm));
        @(negedge clk);
        in_valid = 1'b0;
        sig_in   = 11'($urandom);
        chk("edge1_out_valid", out_valid, 0);
        chk("edge1_in_ready", in_ready, 0);
        @(negedge clk);
        chk("edge2_out_valid", out_valid, 0);
        @(negedge clk);
        chk("edge3_out_valid", out_valid, 1);
        got.sign = sign_out;
        got.e    = exp_out;
        got.s    = sig_out;
        got.ix   = 1'b0;
        got.ov   = 1'b0;
`ifdef FP_ROUND_FLAGS_EN
        got.ix   = flag_inexact;
        got.ov   = flag_overflow;
`endif
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            exp_in   = 5'($urandom);
            @(negedge clk);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_out_valid", out_valid, 0);
        chk("release_in_ready", in_ready, 1);
    endtask

    res_t got;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sign_in   = 1'b0;
        exp_in    = '0;
        sig_in    = '0;
        grs_in    = '0;
        rm_in     = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sign_out", sign_out, 0);
        chk("rst_exp_out", exp_out, 0);
        chk("rst_sig_out", sig_out, 0);
`ifdef FP_ROUND_FLAGS_EN
        chk("rst_flags", {flag_inexact, flag_overflow}, 0);
`endif
        rst = 1'b0;

        run_txn(1'b0, 5'd10, 11'h7FF, 3'b100, 2'd0, 0, got);
        chk("lit_rne_carry_exp", got.e, 5'd11);
        chk("lit_rne_carry_sig", got.s, 11'h400);

        run_txn(1'b0, 5'd10, 11'h402, 3'b100, 2'd0, 1, got);
        chk("lit_rne_tie_even", got.s, 11'h402);
        run_txn(1'b0, 5'd10, 11'h403, 3'b100, 2'd0, 0, got);
        chk("lit_rne_tie_odd", got.s, 11'h404);

        run_txn(1'b0, 5'd10, 11'h7FF, 3'b111, 2'd1, 0, got);
        chk("lit_rtz_sig", got.s, 11'h7FF);
        chk("lit_rtz_exp", got.e, 5'd10);
`ifdef FP_ROUND_FLAGS_EN
        chk("lit_rtz_inexact", got.ix, 1);
`endif

        run_txn(1'b0, 5'd30, 11'h7FF, 3'b100, 2'd0, 0, got);
        chk("lit_ovf_rne_exp", got.e, 5'd31);
        chk("lit_ovf_rne_sig", got.s, 11'h000);
`ifdef FP_ROUND_FLAGS_EN
        chk("lit_ovf_flag", got.ov, 1);
`endif
        run_txn(1'b0, 5'd30, 11'h7FF, 3'b100, 2'd1, 0, got);
        chk("lit_ovf_rtz_exp", got.e, 5'd30);
        chk("lit_ovf_rtz_sig", got.s, 11'h7FF);

        run_txn(1'b1, 5'd12, 11'h500, 3'b111, 2'd2, 0, got);
        chk("lit_rup_neg", got.s, 11'h500);
        run_txn(1'b1, 5'd12, 11'h500, 3'b001, 2'd3, 0, got);
        chk("lit_rdn_neg", got.s, 11'h501);
        chk("lit_rdn_sign", got.sign, 1);

        run_txn(1'b0, 5'd0, 11'h3FF, 3'b100, 2'd0, 0, got);
        chk("lit_subnorm_exp", got.e, 5'd1);
        chk("lit_subnorm_sig", got.s, 11'h400);

        run_txn(1'b0, 5'd31, 11'h123, 3'b111, 2'd2, 0, got);
        chk("lit_special_exp", got.e, 5'd31);
        chk("lit_special_sig", got.s, 11'h123);

        // Backpressure: five stalled cycles, then an immediately following transaction.
        run_txn(1'b0, 5'd7, 11'h2AB, 3'b110, 2'd0, 5, got);
        chk("lit_bp_sig", got.s, 11'h2AC);
        run_txn(1'b1, 5'd7, 11'h2AB, 3'b010, 2'd0, 0, got);
        chk("lit_bp_next_sig", got.s, 11'h2AB);

        // Reset while the operation is in the NORM stage: nothing may emerge.
        @(negedge clk);
        sign_in  = 1'b0;
        exp_in   = 5'd9;
        sig_in   = 11'h7FF;
        grs_in   = 3'b111;
        rm_in    = 2'd0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_exp_out", exp_out, 0);
        chk("midrst_sig_out", sig_out, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("midrst_quiet", out_valid, 0);
        end

        for (int n = 0; n < 300; n++) begin
            logic [4:0]  e;
            logic [10:0] sg;
            int          pick;
            pick = $urandom_range(0, 9);
            case (pick)
                0:       e = 5'd0;
                1:       e = 5'd30;
                2:       e = 5'd31;
                default: e = 5'($urandom_range(1, 29));
            endcase
            sg = ($urandom_range(0, 3) == 0) ? 11'h7FF : 11'($urandom);
            run_txn(1'($urandom), e, sg, 3'($urandom), 2'($urandom), $urandom_range(0, 3), got);
        end

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", expq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
